// File: rtl/c2h_cmpt_gen.sv
// rtl/c2h_cmpt_gen.sv - C2H completion generator: turns accepted packet events into QDMA CMPT entries
module c2h_cmpt_gen #(
  parameter int QID_WIDTH   = 11,
  parameter int QUEUE_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [QID_WIDTH-1:0]         pkt_qid,
  input  logic [15:0]                  pkt_len,
  input  logic                         pkt_err,
  output logic [511:0]                 c2h_cmpt_tdata,
  output logic [1:0]                   c2h_cmpt_size,
  output logic [15:0]                  c2h_cmpt_dpar,
  output logic                         c2h_cmpt_tvalid,
  input  logic                         c2h_cmpt_tready,
  output logic [10:0]                  c2h_cmpt_ctrl_qid,
  output logic [1:0]                   c2h_cmpt_ctrl_cmpt_type,
  output logic [15:0]                  c2h_cmpt_ctrl_wait_pld_pkt_id,
  output logic                         c2h_cmpt_ctrl_marker,
  output logic                         c2h_cmpt_ctrl_user_trig,
  output logic                         c2h_cmpt_ctrl_no_wrb_marker,
  output logic [2:0]                   c2h_cmpt_ctrl_col_idx,
  output logic [2:0]                   c2h_cmpt_ctrl_err_idx,
  output logic [2:0]                   c2h_cmpt_ctrl_port_id,
  output logic [$clog2(QUEUE_DEPTH):0] pending_cnt,
  output logic [31:0]                  cmpt_sent_cnt
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  // Entry layout matches the low bits of tdata: {pkt_id, err, qid, len}
  localparam int EW = 44;

  logic          r_rdy_en;
  logic [15:0]   r_pkt_id;
  logic          r_stg_vld;
  logic [EW-1:0] r_stg;
  logic [EW-1:0] r_mem [QUEUE_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_tvalid;
  logic [EW-1:0] r_out;
  logic [31:0]   r_sent;

  logic [10:0]   w_qid;
  logic [EW-1:0] w_entry_in;
  logic [AW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_near_full;
  logic          w_accept;
  logic          w_slot_free;
  logic          w_pop;

  assign w_qid      = 11'(pkt_qid);
  assign w_entry_in = {r_pkt_id, pkt_err, w_qid, pkt_len};
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // The capture stage always drains into the queue next edge, so it reserves a slot
  assign w_near_full = r_stg_vld && (w_count == (AW+1)'(QUEUE_DEPTH - 1));
  assign pkt_ready   = r_rdy_en && !w_full && !w_near_full;
  assign w_accept    = pkt_valid && pkt_ready;
  assign w_slot_free = !r_tvalid || c2h_cmpt_tready;
  assign w_pop       = !w_empty && w_slot_free;

  // Ready enable and pkt_id counter; entries are captured one cycle before entering the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en  <= 1'b0;
      r_pkt_id  <= 16'd1;
      r_stg_vld <= 1'b0;
      r_stg     <= '0;
    end else begin
      r_rdy_en  <= 1'b1;
      r_stg_vld <= w_accept;
      if (w_accept) begin
        r_stg    <= w_entry_in;
        r_pkt_id <= r_pkt_id + 16'd1;
      end
    end
  end

  // Queue storage, written from the capture stage
  always_ff @(posedge clk) begin
    if (r_stg_vld) r_mem[r_wr_ptr[AW-1:0]] <= r_stg;
  end

  // Queue pointers with an extra wrap bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (r_stg_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Output slot: refill from the queue head whenever empty or being consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_out    <= '0;
    end else if (w_slot_free) begin
      r_tvalid <= !w_empty;
      if (!w_empty) r_out <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Completions accepted by QDMA
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_sent <= '0;
    else if (r_tvalid && c2h_cmpt_tready)   r_sent <= r_sent + 32'd1;
  end

  // Per-word odd parity over the output data
  always_comb begin
    c2h_cmpt_dpar = '0;
    for (int i = 0; i < 16; i++) c2h_cmpt_dpar[i] = ~^c2h_cmpt_tdata[32*i +: 32];
  end

  assign c2h_cmpt_tdata                = {{(512-EW){1'b0}}, r_out};
  assign c2h_cmpt_tvalid               = r_tvalid;
  assign c2h_cmpt_size                 = 2'b00;
  assign c2h_cmpt_ctrl_qid             = r_out[26:16];
  assign c2h_cmpt_ctrl_cmpt_type       = 2'b11;
  assign c2h_cmpt_ctrl_wait_pld_pkt_id = r_out[43:28];
  assign c2h_cmpt_ctrl_marker          = 1'b0;
  assign c2h_cmpt_ctrl_user_trig       = 1'b1;
  assign c2h_cmpt_ctrl_no_wrb_marker   = 1'b0;
  assign c2h_cmpt_ctrl_col_idx         = 3'd0;
  assign c2h_cmpt_ctrl_err_idx         = 3'd0;
  assign c2h_cmpt_ctrl_port_id         = 3'd0;
  assign pending_cnt                   = w_count;
  assign cmpt_sent_cnt                 = r_sent;

endmodule

// File: tb/tb_c2h_cmpt_gen.sv
// tb/tb_c2h_cmpt_gen.sv - testbench for c2h_cmpt_gen against a queue-based reference model
module tb_c2h_cmpt_gen;
  localparam int QW = 11;
  localparam int D  = 16;
  localparam int GW = 571;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pkt_valid = 1'b0;
  logic          pkt_ready;
  logic [QW-1:0] pkt_qid = '0;
  logic [15:0]   pkt_len = '0;
  logic          pkt_err = 1'b0;
  logic [511:0]  c2h_cmpt_tdata;
  logic [1:0]    c2h_cmpt_size;
  logic [15:0]   c2h_cmpt_dpar;
  logic          c2h_cmpt_tvalid;
  logic          c2h_cmpt_tready = 1'b0;
  logic [10:0]   c2h_cmpt_ctrl_qid;
  logic [1:0]    c2h_cmpt_ctrl_cmpt_type;
  logic [15:0]   c2h_cmpt_ctrl_wait_pld_pkt_id;
  logic          c2h_cmpt_ctrl_marker;
  logic          c2h_cmpt_ctrl_user_trig;
  logic          c2h_cmpt_ctrl_no_wrb_marker;
  logic [2:0]    c2h_cmpt_ctrl_col_idx;
  logic [2:0]    c2h_cmpt_ctrl_err_idx;
  logic [2:0]    c2h_cmpt_ctrl_port_id;
  logic [4:0]    pending_cnt;
  logic [31:0]   cmpt_sent_cnt;

  c2h_cmpt_gen #(.QID_WIDTH(QW), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_qid(pkt_qid), .pkt_len(pkt_len), .pkt_err(pkt_err),
    .c2h_cmpt_tdata(c2h_cmpt_tdata), .c2h_cmpt_size(c2h_cmpt_size), .c2h_cmpt_dpar(c2h_cmpt_dpar),
    .c2h_cmpt_tvalid(c2h_cmpt_tvalid), .c2h_cmpt_tready(c2h_cmpt_tready),
    .c2h_cmpt_ctrl_qid(c2h_cmpt_ctrl_qid), .c2h_cmpt_ctrl_cmpt_type(c2h_cmpt_ctrl_cmpt_type),
    .c2h_cmpt_ctrl_wait_pld_pkt_id(c2h_cmpt_ctrl_wait_pld_pkt_id), .c2h_cmpt_ctrl_marker(c2h_cmpt_ctrl_marker),
    .c2h_cmpt_ctrl_user_trig(c2h_cmpt_ctrl_user_trig), .c2h_cmpt_ctrl_no_wrb_marker(c2h_cmpt_ctrl_no_wrb_marker),
    .c2h_cmpt_ctrl_col_idx(c2h_cmpt_ctrl_col_idx), .c2h_cmpt_ctrl_err_idx(c2h_cmpt_ctrl_err_idx),
    .c2h_cmpt_ctrl_port_id(c2h_cmpt_ctrl_port_id), .pending_cnt(pending_cnt), .cmpt_sent_cnt(cmpt_sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] qid;
    logic [15:0] len;
    logic        err;
    logic [15:0] id;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mdl_id = 16'd1;
  int          n_chk  = 0;
  int          n_fail = 0;

  // Expected {ctrl fields, dpar, tdata} of a completion built from the field rules
  function automatic logic [GW-1:0] exp_all(ent_t e);
    logic [511:0] td;
    logic [15:0]  dp;
    td = 512'(e.len) + (512'(e.qid) << 16) + (512'(e.err) << 27) + (512'(e.id) << 28);
    for (int i = 0; i < 16; i++) dp[i] = (($countones(td[32*i +: 32]) % 2) == 0);
    return {2'b00, e.qid, 2'b11, e.id, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, dp, td};
  endfunction

  // One clock: drive at the falling edge, sample before the rising edge, log accepts into the model
  task automatic step(input logic v, input logic [10:0] qid, input logic [15:0] len, input logic er,
                      input logic rdy, output logic acc, output logic hs, output logic tv,
                      output logic [GW-1:0] got);
    ent_t e;
    pkt_valid = v; pkt_qid = qid; pkt_len = len; pkt_err = er; c2h_cmpt_tready = rdy;
    #1;
    acc = v && pkt_ready;
    tv  = c2h_cmpt_tvalid;
    hs  = c2h_cmpt_tvalid && rdy;
    got = {c2h_cmpt_size, c2h_cmpt_ctrl_qid, c2h_cmpt_ctrl_cmpt_type, c2h_cmpt_ctrl_wait_pld_pkt_id,
           c2h_cmpt_ctrl_marker, c2h_cmpt_ctrl_user_trig, c2h_cmpt_ctrl_no_wrb_marker,
           c2h_cmpt_ctrl_col_idx, c2h_cmpt_ctrl_err_idx, c2h_cmpt_ctrl_port_id, c2h_cmpt_dpar, c2h_cmpt_tdata};
    if (acc) begin
      e.qid = qid; e.len = len; e.err = er; e.id = mdl_id;
      mq.push_back(e);
      mdl_id = mdl_id + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; pkt_valid = 1'b0; c2h_cmpt_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    mdl_id = 16'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk += 5;
    if (pkt_ready !== 1'b0)       begin n_fail++; $display("FAIL rst_ready: got %b exp 0", pkt_ready); end
    if (c2h_cmpt_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b exp 0", c2h_cmpt_tvalid); end
    if (pending_cnt !== 5'd0)     begin n_fail++; $display("FAIL rst_pending: got %0d exp 0", pending_cnt); end
    if (cmpt_sent_cnt !== 32'd0)  begin n_fail++; $display("FAIL rst_sent: got %0d exp 0", cmpt_sent_cnt); end
    if (c2h_cmpt_tdata !== '0)    begin n_fail++; $display("FAIL rst_tdata: got %h exp 0", c2h_cmpt_tdata[63:0]); end
    rst = 1'b0;
    #1;
    n_chk++;
    if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b exp 0", pkt_ready); end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (pkt_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b exp 1", pkt_ready); end
  endtask

  task automatic test_single();
    logic acc, hs, tv;
    logic [GW-1:0] got;
    ent_t e;
    int hs_at = -1;
    int n_hs  = 0;
    step(1'b1, 11'd5, 16'h0100, 1'b0, 1'b1, acc, hs, tv, got);
    n_chk++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b exp 1", acc); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 11'd0, 16'd0, 1'b0, 1'b1, acc, hs, tv, got);
      if (hs) begin
        n_hs++;
        if (hs_at < 0) hs_at = k;
        n_chk += 2;
        if (got[63:0] !== 64'h0000_0000_1005_0100) begin n_fail++; $display("FAIL single_tdata: got %h exp 0000000010050100", got[63:0]); end
        if (mq.size() == 0) begin n_fail++; $display("FAIL single_cmpt: unexpected completion %h", got[63:0]); end
        else begin
          e = mq.pop_front();
          if (got !== exp_all(e)) begin n_fail++; $display("FAIL single_cmpt: got %h exp %h", got, exp_all(e)); end
        end
      end
    end
    n_chk += 4;
    if (hs_at !== 2)              begin n_fail++; $display("FAIL single_latency: got %0d exp 2", hs_at); end
    if (n_hs !== 1)               begin n_fail++; $display("FAIL single_count: got %0d exp 1", n_hs); end
    if (cmpt_sent_cnt !== 32'd1)  begin n_fail++; $display("FAIL single_sent: got %0d exp 1", cmpt_sent_cnt); end
    if (c2h_cmpt_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 0", c2h_cmpt_tvalid); end
  endtask

  task automatic test_full();
    logic acc, hs, tv;
    logic [GW-1:0] got;
    ent_t e;
    int accepted = 0;
    do_reset();
    for (int k = 0; k < 40 && accepted < D + 1; k++) begin
      step(1'b1, 11'($urandom), 16'($urandom), 1'($urandom), 1'b0, acc, hs, tv, got);
      if (acc) accepted++;
    end
    n_chk++;
    if (accepted !== D + 1) begin n_fail++; $display("FAIL full_accepted: got %0d exp %0d", accepted, D + 1); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 11'($urandom), 16'($urandom), 1'($urandom), 1'b0, acc, hs, tv, got);
      n_chk++;
      if (acc !== 1'b0) begin n_fail++; $display("FAIL full_refuse: got %b exp 0", acc); end
    end
    #1;
    n_chk += 3;
    if (pending_cnt !== 5'(D))    begin n_fail++; $display("FAIL full_pending: got %0d exp %0d", pending_cnt, D); end
    if (pkt_ready !== 1'b0)       begin n_fail++; $display("FAIL full_ready: got %b exp 0", pkt_ready); end
    if (c2h_cmpt_tvalid !== 1'b1) begin n_fail++; $display("FAIL full_tvalid: got %b exp 1", c2h_cmpt_tvalid); end
    for (int k = 0; k < 100 && mq.size() > 0; k++) begin
      step(1'b0, 11'd0, 16'd0, 1'b0, 1'b1, acc, hs, tv, got);
      if (hs) begin
        e = mq.pop_front();
        n_chk++;
        if (got !== exp_all(e)) begin n_fail++; $display("FAIL full_cmpt: got %h exp %h", got, exp_all(e)); end
      end
    end
    n_chk += 2;
    if (mq.size() !== 0)          begin n_fail++; $display("FAIL full_drain: got %0d left exp 0", mq.size()); end
    if (cmpt_sent_cnt !== 32'(D + 1)) begin n_fail++; $display("FAIL full_sent: got %0d exp %0d", cmpt_sent_cnt, D + 1); end
  endtask

  task automatic test_back_to_back();
    logic acc, hs, tv;
    logic [GW-1:0] got;
    ent_t e;
    int n_acc = 0, n_hs = 0, first_hs = -1, last_hs = -1;
    for (int k = 0; k < 60; k++) begin
      step(k < 20, 11'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc, hs, tv, got);
      if (acc) n_acc++;
      n_chk++;
      if (pending_cnt > 5'd1) begin n_fail++; $display("FAIL b2b_pending: got %0d exp <=1", pending_cnt); end
      if (hs) begin
        n_hs++;
        if (first_hs < 0) first_hs = k;
        last_hs = k;
        n_chk++;
        if (mq.size() == 0) begin n_fail++; $display("FAIL b2b_cmpt: unexpected completion %h", got[63:0]); end
        else begin
          e = mq.pop_front();
          if (got !== exp_all(e)) begin n_fail++; $display("FAIL b2b_cmpt: got %h exp %h", got, exp_all(e)); end
        end
      end
    end
    n_chk += 4;
    if (n_acc !== 20)               begin n_fail++; $display("FAIL b2b_accepted: got %0d exp 20", n_acc); end
    if (n_hs !== 20)                begin n_fail++; $display("FAIL b2b_count: got %0d exp 20", n_hs); end
    if (first_hs !== 3)             begin n_fail++; $display("FAIL b2b_latency: got %0d exp 3", first_hs); end
    if (last_hs - first_hs !== 19)  begin n_fail++; $display("FAIL b2b_rate: got %0d exp 19", last_hs - first_hs); end
  endtask

  task automatic test_random_stall();
    logic acc, hs, tv, rdy;
    logic [GW-1:0] got, prev_got;
    ent_t e;
    logic prev_stall = 1'b0;
    prev_got = '0;
    for (int k = 0; k < 500; k++) begin
      rdy = (k >= 400) || ($urandom_range(0, 2) != 0);
      step((k < 400) && ($urandom_range(0, 1) == 1), 11'($urandom), 16'($urandom), 1'($urandom), rdy, acc, hs, tv, got);
      if (prev_stall) begin
        n_chk++;
        if (tv !== 1'b1 || got !== prev_got) begin n_fail++; $display("FAIL rand_stable: tv %b got %h exp %h", tv, got[63:0], prev_got[63:0]); end
      end
      prev_stall = tv && !rdy;
      prev_got   = got;
      if (hs) begin
        n_chk++;
        if (mq.size() == 0) begin n_fail++; $display("FAIL rand_cmpt: unexpected completion %h", got[63:0]); end
        else begin
          e = mq.pop_front();
          if (got !== exp_all(e)) begin n_fail++; $display("FAIL rand_cmpt: got %h exp %h", got, exp_all(e)); end
        end
      end
    end
    n_chk++;
    if (mq.size() !== 0) begin n_fail++; $display("FAIL rand_drain: got %0d left exp 0", mq.size()); end
  endtask

  task automatic test_reset_mid();
    logic acc, hs, tv;
    logic [GW-1:0] got;
    ent_t e;
    int n_hs = 0;
    for (int k = 0; k < 20 && pending_cnt < 5'd3; k++)
      step(1'b1, 11'($urandom), 16'($urandom), 1'($urandom), 1'b0, acc, hs, tv, got);
    pkt_valid = 1'b0;
    #1;
    n_chk += 2;
    if (pending_cnt !== 5'd3)     begin n_fail++; $display("FAIL mid_pending_pre: got %0d exp 3", pending_cnt); end
    if (c2h_cmpt_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_tvalid_pre: got %b exp 1", c2h_cmpt_tvalid); end
    rst = 1'b1;
    #1;
    n_chk += 3;
    if (c2h_cmpt_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b exp 0", c2h_cmpt_tvalid); end
    if (pending_cnt !== 5'd0)     begin n_fail++; $display("FAIL mid_pending: got %0d exp 0", pending_cnt); end
    if (pkt_ready !== 1'b0)       begin n_fail++; $display("FAIL mid_ready: got %b exp 0", pkt_ready); end
    mq.delete();
    mdl_id = 16'd1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 11'h7ff, 16'hbeef, 1'b1, 1'b1, acc, hs, tv, got);
    for (int k = 0; k < 10 && mq.size() > 0; k++) begin
      step(1'b0, 11'd0, 16'd0, 1'b0, 1'b1, acc, hs, tv, got);
      if (hs) begin
        n_hs++;
        e = mq.pop_front();
        n_chk += 2;
        if (got[43:28] !== 16'd1) begin n_fail++; $display("FAIL mid_first_id: got %h exp 0001", got[43:28]); end
        if (got !== exp_all(e))   begin n_fail++; $display("FAIL mid_cmpt: got %h exp %h", got, exp_all(e)); end
      end
    end
    n_chk++;
    if (n_hs !== 1) begin n_fail++; $display("FAIL mid_count: got %0d exp 1", n_hs); end
  endtask

  task automatic test_wrap();
    logic acc, hs, tv;
    logic [GW-1:0] got;
    ent_t e;
    int n_acc = 0;
    logic [15:0] ids[$];
    do_reset();
    for (int k = 0; k < 70000 && n_acc < 65536; k++) begin
      step(n_acc < 65536, 11'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc, hs, tv, got);
      if (acc) n_acc++;
      if (hs) begin
        ids.push_back(got[43:28]);
        if (ids.size() > 2) void'(ids.pop_front());
        n_chk++;
        if (mq.size() == 0) begin n_fail++; $display("FAIL wrap_cmpt: unexpected completion %h", got[63:0]); end
        else begin
          e = mq.pop_front();
          if (got !== exp_all(e)) begin n_fail++; $display("FAIL wrap_cmpt: got %h exp %h", got, exp_all(e)); end
        end
      end
    end
    for (int k = 0; k < 10 && mq.size() > 0; k++) begin
      step(1'b0, 11'd0, 16'd0, 1'b0, 1'b1, acc, hs, tv, got);
      if (hs) begin
        ids.push_back(got[43:28]);
        if (ids.size() > 2) void'(ids.pop_front());
        e = mq.pop_front();
        n_chk++;
        if (got !== exp_all(e)) begin n_fail++; $display("FAIL wrap_cmpt: got %h exp %h", got, exp_all(e)); end
      end
    end
    n_chk += 3;
    if (mq.size() !== 0) begin n_fail++; $display("FAIL wrap_drain: got %0d left exp 0", mq.size()); end
    if (ids.size() !== 2 || ids[0] !== 16'hffff || ids[1] !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_ids: got %0d ids exp ffff,0000", ids.size());
    end
    if (cmpt_sent_cnt !== 32'd65536) begin n_fail++; $display("FAIL wrap_sent: got %0d exp 65536", cmpt_sent_cnt); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
